// File: rtl/cmos_16_8bit_tx.sv
// DVP camera-stream generator: serializes 16-bit RGB565 pixels into an 8-bit
// vsync/href byte stream (high byte first) with fixed, parameterized frame geometry.
module cmos_16_8bit_tx #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned VS_LEN   = 8,
  parameter int unsigned VBP      = 32,
  parameter int unsigned VFP      = 32
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  pdata_o,
  output logic        href_o,
  output logic        vsync_o,
  output logic        frame_done,
  output logic        underrun
);

  localparam int unsigned CW = 12;
  localparam int unsigned BW = 16;

  localparam logic [CW-1:0] LINE_LAST = CW'(2 * H_ACTIVE - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] VS_LAST   = BW'(VS_LEN - 1);
  localparam logic [BW-1:0] VBP_LAST  = BW'(VBP - 1);
  localparam logic [BW-1:0] HB_LAST   = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VFP_LAST  = BW'(VFP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_HBLANK,
    S_VFP
  } state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [CW-1:0] line_cnt;
  logic [BW-1:0] blank_cnt;
  logic [7:0]    lo_byte;

  // Byte phase is the LSB of the byte counter; phase 0 is the pixel slot.
  always_comb begin
    pix_ready = (state == S_ACTIVE) && !byte_cnt[0];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      blank_cnt  <= '0;
      lo_byte    <= '0;
      pdata_o    <= '0;
      href_o     <= 1'b0;
      vsync_o    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      // Pins follow the current state with one cycle of latency.
      vsync_o    <= (state == S_VSYNC);
      href_o     <= (state == S_ACTIVE);
      pdata_o    <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (enable) begin
            state     <= S_VSYNC;
            blank_cnt <= '0;
          end
        end

        S_VSYNC: begin
          if (blank_cnt == VS_LAST) begin
            state     <= S_VBP;
            blank_cnt <= '0;
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end

        S_VBP: begin
          if (blank_cnt == VBP_LAST) begin
            state    <= S_ACTIVE;
            byte_cnt <= '0;
            line_cnt <= '0;
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end

        S_ACTIVE: begin
          // A missing pixel is replaced by zeros so line timing never slips.
          if (!byte_cnt[0]) begin
            pdata_o  <= pix_valid ? pix_data[15:8] : 8'h00;
            lo_byte  <= pix_valid ? pix_data[7:0]  : 8'h00;
            underrun <= !pix_valid;
          end else begin
            pdata_o  <= lo_byte;
          end
          if (byte_cnt == LINE_LAST) begin
            state     <= S_HBLANK;
            blank_cnt <= '0;
          end else begin
            byte_cnt <= byte_cnt + CW'(1);
          end
        end

        S_HBLANK: begin
          if (blank_cnt == HB_LAST) begin
            blank_cnt <= '0;
            if (line_cnt < V_LAST) begin
              state    <= S_ACTIVE;
              byte_cnt <= '0;
              line_cnt <= line_cnt + CW'(1);
            end else begin
              state <= S_VFP;
            end
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end

        S_VFP: begin
          if (blank_cnt == VFP_LAST) begin
            frame_done <= 1'b1;
            blank_cnt  <= '0;
            state      <= enable ? S_VSYNC : S_IDLE;
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_16_8bit_tx.sv
// Directed bench for cmos_16_8bit_tx with a tiny 4x2 frame geometry.
module tb_cmos_16_8bit_tx;

  logic        pclk;
  logic        rst_n;
  logic        enable;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pdata_o;
  logic        href_o;
  logic        vsync_o;
  logic        frame_done;
  logic        underrun;

  int n_vec  = 0;
  int n_miss = 0;

  logic drop_en = 1'b0;
  int   src_idx;
  int   src_slot;

  cmos_16_8bit_tx #(
    .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3), .VS_LEN(2), .VBP(2), .VFP(2)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .enable(enable),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pdata_o(pdata_o), .href_o(href_o), .vsync_o(vsync_o),
    .frame_done(frame_done), .underrun(underrun)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pixel k of a frame: A1B2, C3D4, E5F6, ...
  function automatic logic [15:0] pix(input int k);
    logic [7:0] h, l;
    h = 8'hA1 + 8'(k * 34);
    l = 8'hB2 + 8'(k * 34);
    return {h, l};
  endfunction

  // Expected pixel in slot s of a frame when slot 2 may be starved.
  function automatic logic [15:0] slot_pix(input int s, input bit drop);
    if (drop && s == 2) return 16'h0000;
    return pix((drop && s > 2) ? s - 1 : s);
  endfunction

  // Pixel source: frame-relative index, restarts at every vsync.
  initial begin
    pix_data  = '0;
    pix_valid = 1'b0;
    src_idx   = 0;
    src_slot  = 0;
    forever begin
      @(negedge pclk);
      if (vsync_o) begin
        src_idx  = 0;
        src_slot = 0;
      end
      pix_valid = !(drop_en && src_slot == 2);
      pix_data  = pix(src_idx);
      if (pix_ready) begin
        if (pix_valid) src_idx++;
        src_slot++;
      end
    end
  end

  always @(negedge pclk) chk("vsync_and_href", 32'(vsync_o & href_o), 32'd0);

  // Checks one 28-cycle frame starting at the vsync rise (t=0 = first vsync cycle).
  task automatic check_frame(input bit drop, input int en_off_t);
    int wait_n;
    int n_rdy;
    int off, line, b;
    logic        e_vs, e_hr, e_fd, e_ur, e_rdy, nxt_hi;
    logic [7:0]  e_pd;
    logic [15:0] p;
    wait_n = 0;
    while (!vsync_o && wait_n < 100) begin
      @(negedge pclk);
      wait_n++;
    end
    if (!vsync_o) begin
      chk("vsync_timeout", 32'd0, 32'd1);
      return;
    end
    n_rdy = 0;
    for (int t = 0; t < 28; t++) begin
      if (t == en_off_t) enable = 1'b0;
      e_vs = (t < 2);
      e_hr = (t >= 4 && t < 12) || (t >= 15 && t < 23);
      e_fd = (t == 27);
      e_pd = 8'h00;
      e_ur = 1'b0;
      if (e_hr) begin
        line = (t < 12) ? 0 : 1;
        off  = (t < 12) ? t - 4 : t - 15;
        b    = off % 2;
        p    = slot_pix(line * 4 + off / 2, drop);
        e_pd = (b == 0) ? p[15:8] : p[7:0];
        e_ur = drop && (line * 4 + off / 2 == 2) && (b == 0);
      end
      nxt_hi = ((t + 1 >= 4 && t + 1 < 12) && ((t + 1 - 4) % 2 == 0)) ||
               ((t + 1 >= 15 && t + 1 < 23) && ((t + 1 - 15) % 2 == 0));
      e_rdy = nxt_hi;
      chk($sformatf("vsync t%0d", t), 32'(vsync_o), 32'(e_vs));
      chk($sformatf("href t%0d", t), 32'(href_o), 32'(e_hr));
      chk($sformatf("pdata t%0d", t), 32'(pdata_o), 32'(e_pd));
      chk($sformatf("frame_done t%0d", t), 32'(frame_done), 32'(e_fd));
      chk($sformatf("underrun t%0d", t), 32'(underrun), 32'(e_ur));
      chk($sformatf("pix_ready t%0d", t), 32'(pix_ready), 32'(e_rdy));
      if (pix_ready) n_rdy++;
      @(negedge pclk);
    end
    chk("ready_count", 32'(n_rdy), 32'd8);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
    chk({tag, "_pdata"}, 32'(pdata_o), 32'd0);
    chk({tag, "_href"}, 32'(href_o), 32'd0);
    chk({tag, "_vsync"}, 32'(vsync_o), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    int wait_n;
    rst_n  = 1'b0;
    enable = 1'b0;
    #22;
    check_idle_outputs("reset");
    @(negedge pclk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("idle_no_vsync", 32'(vsync_o), 32'd0);
    end

    // Start: vsync rises on the 2nd edge after enable is seen.
    enable = 1'b1;
    @(negedge pclk);
    chk("vsync_edge1", 32'(vsync_o), 32'd0);
    @(negedge pclk);
    chk("vsync_edge2", 32'(vsync_o), 32'd1);

    check_frame(1'b0, -1);
    drop_en = 1'b1;
    check_frame(1'b1, -1);
    drop_en = 1'b0;

    // enable dropped during line 1: frame finishes, then the block idles.
    check_frame(1'b0, 18);
    for (int i = 0; i < 8; i++) begin
      chk("stopped_no_vsync", 32'(vsync_o), 32'd0);
      @(negedge pclk);
    end
    enable = 1'b1;
    @(negedge pclk);
    chk("restart_edge1", 32'(vsync_o), 32'd0);
    @(negedge pclk);
    chk("restart_edge2", 32'(vsync_o), 32'd1);
    check_frame(1'b0, -1);

    // Asynchronous reset in the middle of an href pulse.
    wait_n = 0;
    while (!href_o && wait_n < 100) begin
      @(negedge pclk);
      wait_n++;
    end
    chk("href_before_reset", 32'(href_o), 32'd1);
    @(negedge pclk);
    @(negedge pclk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge pclk);
    @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    chk("post_reset_edge1", 32'(vsync_o), 32'd0);
    @(negedge pclk);
    chk("post_reset_edge2", 32'(vsync_o), 32'd1);
    check_frame(1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
